asu32_serial: RTL and testbench
===============================

# asu32_serial

Sequential 32-bit add/subtract unit that is the inverse-capable, multi-cycle counterpart of the combinational 32-bit ripple-carry adder. It processes operands one SLICE-bit group per clock, LSB first, through a single slice adder with a registered carry. A start/busy/done handshake wraps the datapath so a controller can issue add or subtract requests. Area scales with SLICE instead of 32 bits, at the cost of 32/SLICE cycles of latency.

## Interface
- SLICE, 4, bits processed per cycle; legal values 1, 2, 4, 8, 16, 32; N = 32/SLICE
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; accepted only when busy=0
- op  input  1  0 = add (a+b+ci), 1 = subtract (a-b-ci)
- a  input  32  operand A, sampled on the accepting edge
- b  input  32  operand B, sampled on the accepting edge
- ci  input  1  carry-in (add) or borrow-in (subtract), sampled on the accepting edge
- s  output  32  result, registered
- co  output  1  raw carry out of bit 31; for subtract, co=1 means no borrow
- busy  output  1  high while the unit is in RUN
- done  output  1  one-cycle completion pulse
- ovf  output  1  signed overflow; present only with ASU32_OVF_EN

## Operation
- States: IDLE, RUN, DONE. Reset puts the unit in IDLE.
- IDLE or DONE, start=1:
  - latch opA=a and opB = op ? ~b : b
  - set carry = op ? ~ci : ci
  - clear slice index k=0
  - go to RUN
- Subtract is therefore a + ~b + ~ci, which equals a-b-ci mod 2^32.
- RUN, each cycle:
  - sum = opA[k] + opB[k] + carry, with [k] = bits k*SLICE+SLICE-1 : k*SLICE
  - write the low SLICE bits of sum into the internal result register slice k
  - carry = sum[SLICE]
  - k = k+1
- RUN, on the cycle with k=N-1: go to DONE.
- DONE:
  - load s from the internal result register and co from the final carry
  - done=1 for exactly this cycle
  - next state is RUN if start=1, else IDLE
- start while busy=1 is ignored: no latch, no extra done.
- s and co hold their last values until the next completion. The output s does not change during RUN.
- op, a, b and ci may change freely after the accepting edge.

## Timing
- Reset values: s=0, co=0, busy=0, done=0, ovf=0, state IDLE, internal registers 0.
- Edge E0: start accepted; busy=1 from E0.
- Edges E1..EN: RUN edges processing slices 0..N-1.
- After EN: state DONE, busy=0, done=1, s/co/ovf valid.
- done is seen N cycles after the accepting edge (8 cycles for SLICE=4).
- Back-to-back: start held during the DONE cycle launches the next operation with no idle cycle. Throughput is one result per N+1 cycles.
- reset asserted at any point, including mid-RUN:
  - outputs return immediately to their reset values
  - the in-flight operation is discarded with no done
  - start is honoured on the first edge after reset deasserts
- SLICE=32: single RUN cycle, so done arrives 1 cycle after the accepting edge.

## Configuration
- ASU32_OVF_EN defined:
  - ovf port present
  - ovf = (carry into bit 31) XOR (carry out of bit 31), registered with s in DONE, held until the next completion
  - carry into bit 31 is captured during the last RUN cycle
- ASU32_OVF_EN undefined: ovf port and its logic are absent; all other behaviour is identical.

## Test plan
- Add, a=0000_0001, b=0000_0001, ci=1 (SLICE=4) -> s=0000_0003, co=0; done exactly 8 cycles after the accepting edge, busy high for those 8 cycles.
- Carry chain per nibble:
  - a=0000_000F, b=0000_0001 -> s=0000_0010, co=0
  - a=F000_0000, b=1000_0000 -> s=0000_0000, co=1
  - sweep the same pattern through all 8 nibble positions
- Subtract:
  - op=1, a=0000_0005, b=0000_0003, ci=0 -> s=0000_0002, co=1
  - a=0, b=1, ci=0 -> s=FFFF_FFFF, co=0
  - a=5, b=3, ci=1 -> s=0000_0001, co=1
- Handshake:
  - start a second request 3 cycles into RUN with different operands -> ignored; a single done with the first result
  - start held during DONE -> next done follows 9 cycles after the first
- Reset mid-RUN at cycle 4 -> s=0, co=0, busy=0, no done pulse. A fresh add 0000_00F0+0000_0010 then gives s=0000_0100, co=0.
- With ASU32_OVF_EN:
  - add 7FFF_FFFF+0000_0001 -> s=8000_0000, co=0, ovf=1
  - subtract 8000_0000-0000_0001 -> s=7FFF_FFFF, ovf=1
  - repeat with SLICE=1 -> identical results, done 32 cycles after accept

Source files
------------

// File: rtl/asu32_serial_if.sv
// asu32_serial_if: start/busy/done handshake and operand/result bus for asu32_serial (ovf present with ASU32_OVF_EN)
interface asu32_serial_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic [31:0] s;
  logic        co;
  logic        busy;
  logic        done;
`ifdef ASU32_OVF_EN
  logic        ovf;
`endif
  modport master (
    output start, op, a, b, ci,
    input  s, co, busy, done
`ifdef ASU32_OVF_EN
    , input ovf
`endif
  );
  modport slave (
    input  start, op, a, b, ci,
    output s, co, busy, done
`ifdef ASU32_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/asu32_serial.sv
// asu32_serial: 32-bit add/subtract processed SLICE bits per clock through one slice adder (signed overflow with ASU32_OVF_EN)
module asu32_serial #(
  parameter int SLICE = 4
) (
  input logic clk,
  input logic reset,
  asu32_serial_if.slave bus
);
  localparam int N  = 32 / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          r_state, w_next;
  logic [31:0]     r_opa, r_opb, r_res, w_res, r_s;
  logic            r_carry, r_co;
  logic [KW-1:0]   r_k;
  logic [SLICE:0]  w_sum;
  logic            w_last, w_accept;
`ifdef ASU32_OVF_EN
  logic            r_ovf, w_c31;
`endif
  // a request is taken whenever the unit is not mid-operation
  assign w_accept = bus.start && (r_state != RUN);
  assign w_last   = (r_k == KW'(N - 1));
  // slice adder: current slice of both operands plus the carry, merged into the running result
  always_comb begin
    w_sum = {1'b0, r_opa[r_k*SLICE +: SLICE]} + {1'b0, r_opb[r_k*SLICE +: SLICE]} + {{SLICE{1'b0}}, r_carry};
    w_res = r_res;
    w_res[r_k*SLICE +: SLICE] = w_sum[SLICE-1:0];
`ifdef ASU32_OVF_EN
    w_c31 = r_opa[31] ^ r_opb[31] ^ w_res[31];
`endif
  end
  // next state: RUN until the last slice, then one DONE cycle that may relaunch
  always_comb begin
    w_next = r_state;
    w_next = (r_state == RUN) ? (w_last ? DONE : RUN) : (bus.start ? RUN : IDLE);
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // operand capture, slice iteration and result publication on the last slice
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
`ifdef ASU32_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_opa   <= bus.a;
      r_opb   <= bus.op ? ~bus.b : bus.b;
      r_carry <= bus.op ? ~bus.ci : bus.ci;
      r_k     <= '0;
    end else if (r_state == RUN) begin
      r_res   <= w_res;
      r_carry <= w_sum[SLICE];
      r_k     <= r_k + 1'b1;
      if (w_last) begin
        r_s   <= w_res;
        r_co  <= w_sum[SLICE];
`ifdef ASU32_OVF_EN
        r_ovf <= w_c31 ^ w_sum[SLICE];
`endif
      end
    end
  end
  assign bus.s    = r_s;
  assign bus.co   = r_co;
  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
`ifdef ASU32_OVF_EN
  assign bus.ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_asu32_serial.sv
// tb_asu32_serial: vector table, handshake/reset sequences and random ops against an arithmetic model
module tb_asu32_serial;
  localparam int SLICE = 4;
  localparam int N = 32 / SLICE;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  asu32_serial_if bus();
  asu32_serial #(.SLICE(SLICE)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] s;
    logic        co;
  } vec_t;
  vec_t tbl[$];
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  function automatic logic [33:0] model(input logic op, input logic [31:0] a, input logic [31:0] b, input logic ci);
    longint sa, sb, r;
    logic [32:0] u;
    logic v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op) begin
      u = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      r = sa + sb + longint'(ci);
    end else begin
      u[31:0] = a - b - {31'd0, ci};
      u[32] = ({1'b0, a} >= ({1'b0, b} + {32'd0, ci}));
      r = sa - sb - longint'(ci);
    end
    v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {v, u};
  endfunction
  function automatic logic get_ovf();
`ifdef ASU32_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b, input logic ci,
                        output logic [31:0] s, output logic co, output logic ovf,
                        output int lat, output int busy_bad, output int s_moved);
    logic [31:0] s0;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.ci = ci;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 1'($urandom); bus.a = $urandom; bus.b = $urandom; bus.ci = 1'($urandom);
    s0 = bus.s; lat = 0; busy_bad = 0; s_moved = 0;
    while (!bus.done && lat < 4 * N + 8) begin
      if (!bus.busy) busy_bad++;
      if (bus.s !== s0) s_moved++;
      @(posedge clk); #1;
      lat++;
    end
    s = bus.s; co = bus.co; ovf = get_ovf();
  endtask
  initial begin
    logic [31:0] s, ra, rb;
    logic co, ovf, rop, rci;
    logic [33:0] m;
    int lat, bb, sm, t, dones, gap;
    vec_t v;
    tbl.push_back('{1'b0, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0003, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0});
    tbl.push_back('{1'b0, 32'hF000_0000, 32'h1000_0000, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b1});
    tbl.push_back('{1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 1'b1});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b0, 32'hF << (4 * i), 32'h1 << (4 * i), 1'b0, (i == 7) ? 32'h0 : (32'h10 << (4 * i)), (i == 7)});
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_s", bus.s, 0);
    chk("reset_co", bus.co, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_ovf", get_ovf(), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      v = tbl[i];
      run_op(v.op, v.a, v.b, v.ci, s, co, ovf, lat, bb, sm);
      chk($sformatf("vec%0d_s", i), s, v.s);
      chk($sformatf("vec%0d_co", i), co, v.co);
      chk($sformatf("vec%0d_latency", i), lat, N);
      chk($sformatf("vec%0d_busy_low_in_run", i), bb, 0);
      chk($sformatf("vec%0d_s_moved_in_run", i), sm, 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_one_cycle", i), bus.done, 0);
    end
    // a second start three cycles into RUN must be ignored
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h1111_1111; bus.b = 32'h2222_2222; bus.ci = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0; t = 0; dones = 0; gap = -1; s = '0;
    for (int i = 0; i < 3 * N; i++) begin
      if (t == 3) begin bus.start = 1'b1; bus.a = 32'h0505_0505; bus.b = 32'h0101_0101; bus.op = 1'b1; end
      else bus.start = 1'b0;
      if (bus.done) begin dones++; if (gap < 0) begin gap = t; s = bus.s; end end
      @(posedge clk); #1;
      t++;
    end
    bus.start = 1'b0;
    chk("ignored_start_dones", dones, 1);
    chk("ignored_start_latency", gap, N);
    chk("ignored_start_s", s, 32'h3333_3333);
    // start held in DONE launches the next op immediately
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h0000_0100; bus.b = 32'h0000_0023; bus.ci = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0; t = 0;
    while (!bus.done && t < 4 * N) begin @(posedge clk); #1; t++; end
    chk("b2b_first_s", bus.s, 32'h0000_0123);
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'h0000_0100; bus.b = 32'h0000_0001; bus.ci = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; gap = 1;
    chk("b2b_busy_after_done", bus.busy, 1);
    while (!bus.done && gap < 4 * N) begin @(posedge clk); #1; gap++; end
    chk("b2b_gap", gap, N + 1);
    chk("b2b_second_s", bus.s, 32'h0000_00FE);
    chk("b2b_second_co", bus.co, 1);
    @(posedge clk); #1;
    // reset in the middle of RUN discards the operation
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.ci = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrun_reset_s", bus.s, 0);
    chk("midrun_reset_co", bus.co, 0);
    chk("midrun_reset_busy", bus.busy, 0);
    chk("midrun_reset_done", bus.done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < N + 4; i++) begin
      if (bus.done || bus.busy) dones++;
      @(posedge clk); #1;
    end
    chk("midrun_reset_no_done", dones, 0);
    run_op(1'b0, 32'h0000_00F0, 32'h0000_0010, 1'b0, s, co, ovf, lat, bb, sm);
    chk("after_reset_s", s, 32'h0000_0100);
    chk("after_reset_co", co, 0);
    @(posedge clk); #1;
`ifdef ASU32_OVF_EN
    run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, s, co, ovf, lat, bb, sm);
    chk("ovf_add_s", s, 32'h8000_0000);
    chk("ovf_add_co", co, 0);
    chk("ovf_add_ovf", ovf, 1);
    @(posedge clk); #1;
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, s, co, ovf, lat, bb, sm);
    chk("ovf_sub_s", s, 32'h7FFF_FFFF);
    chk("ovf_sub_ovf", ovf, 1);
    @(posedge clk); #1;
`endif
    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom); ra = $urandom; rb = $urandom; rci = 1'($urandom);
      if (i % 4 == 0) rb = ra ^ 32'h8000_0000;
      m = model(rop, ra, rb, rci);
      run_op(rop, ra, rb, rci, s, co, ovf, lat, bb, sm);
      chk($sformatf("rnd%0d_s", i), s, m[31:0]);
      chk($sformatf("rnd%0d_co", i), co, m[32]);
`ifdef ASU32_OVF_EN
      chk($sformatf("rnd%0d_ovf", i), ovf, m[33]);
`endif
      chk($sformatf("rnd%0d_latency", i), lat, N);
      if (i % 2 == 0) begin @(posedge clk); #1; end
      else begin
        while (bus.done) begin @(posedge clk); #1; end
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
